// File: rtl/bram_client_pkg.sv
// Shared types and elaboration helpers for the BRAM port client.
// The macro BRAM_PORT_CLIENT_WRITE_ACK_EN (used by bram_port_client) makes writes return a response.
package bram_client_pkg;

   // Deepest return pipe supported: PIPELINED BRAM gives two cycles EN -> DO
   localparam int unsigned MAX_LAT = 2;

   // One valid bit per return-pipe stage; only the low LAT bits are ever set
   typedef logic [MAX_LAT-1:0] ret_tags_t;

   // Cycles from BRAM EN to DO valid
   function automatic int unsigned lat_f(input int unsigned pipelined);
      return 1 + ((pipelined != 0) ? 1 : 0);
   endfunction

   // Width of a counter holding 0..depth inclusive
   function automatic int unsigned cnt_width_f(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Synchronous response FIFO (DATA_WIDTH x DEPTH), sync active-high reset.
// No bypass: a word pushed into an empty FIFO becomes visible the next cycle.
module bram_resp_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         occ_q;

   assign dout_o  = mem_q[rd_q];
   assign full_o  = (occ_q == CW'(DEPTH));
   assign empty_o = (occ_q == '0);

   // Storage: written on push, no reset needed
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_q] <= din_i;
      end
   end

   // Pointers and occupancy; simultaneous push/pop leaves occupancy unchanged
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         if (push_i) begin
            wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
         end
         if (pop_i) begin
            rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
         end
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/bram_port_client.sv
// Request-side initiator for one port of a write-first byte-enable BRAM.
// Credit-based: outstanding responding requests + FIFO occupancy never exceed RESP_DEPTH.
// Define BRAM_PORT_CLIENT_WRITE_ACK_EN to make writes consume a credit and return the written word.
module bram_port_client
   import bram_client_pkg::*;
#(
   parameter int unsigned PIPELINED  = 0,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CHUNKSIZE  = 8,
   parameter int unsigned WE_WIDTH   = 4,
   parameter int unsigned RESP_DEPTH = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_RDY,
   input  logic [WE_WIDTH-1:0]   REQ_WE,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [DATA_WIDTH-1:0] REQ_DATA,
   output logic                  RESP_VALID,
   input  logic                  RESP_RDY,
   output logic [DATA_WIDTH-1:0] RESP_DATA,
   output logic                  BRAM_EN,
   output logic [WE_WIDTH-1:0]   BRAM_WE,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic [DATA_WIDTH-1:0] BRAM_DI,
   input  logic [DATA_WIDTH-1:0] BRAM_DO
);
   localparam int unsigned LAT       = lat_f(PIPELINED);
   localparam int unsigned CW        = cnt_width_f(RESP_DEPTH);
   localparam ret_tags_t   LAT_MASK  = ret_tags_t'((1 << LAT) - 1);
   localparam ret_tags_t   LAST_MASK = ret_tags_t'(1 << (LAT - 1));

   logic          fire, resp_req, push, pop, fifo_full, fifo_empty;
   ret_tags_t     tags_q, tags_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Ready depends only on registered credit state, never on RESP_RDY
   assign REQ_RDY = !RST && (cnt_q < CW'(RESP_DEPTH));
   assign fire    = REQ_VALID && REQ_RDY;

`ifdef BRAM_PORT_CLIENT_WRITE_ACK_EN
   assign resp_req = fire;
`else
   assign resp_req = fire && (REQ_WE == '0);
`endif

   assign BRAM_EN   = fire;
   assign BRAM_WE   = fire ? REQ_WE : '0;
   assign BRAM_ADDR = REQ_ADDR;
   assign BRAM_DI   = REQ_DATA;

   // Tag reaches the last stage exactly when BRAM_DO holds that request's word
   assign tags_d     = {tags_q[MAX_LAT-2:0], resp_req} & LAT_MASK;
   assign push       = |(tags_q & LAST_MASK);
   assign RESP_VALID = !fifo_empty;
   assign pop        = RESP_VALID && RESP_RDY;

   // Credit count: +1 per responding fire, -1 per pop
   always_comb begin
      cnt_d = cnt_q;
      case ({resp_req, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Return-pipe tags and credits; reset drops any in-flight returns
   always_ff @(posedge CLK) begin
      if (RST) begin
         tags_q <= '0;
         cnt_q  <= '0;
      end else begin
         tags_q <= tags_d;
         cnt_q  <= cnt_d;
      end
   end

   bram_resp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RESP_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (push),
      .din_i   (BRAM_DO),
      .pop_i   (pop),
      .dout_o  (RESP_DATA),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && fifo_full));

   a_req_stable: assert property (@(posedge CLK) disable iff (RST)
      (REQ_VALID && !REQ_RDY) |=> (REQ_VALID && $stable(REQ_WE) && $stable(REQ_ADDR) && $stable(REQ_DATA)));

endmodule

// File: tb/tb_bram_port_client.sv
// Self-checking bench: one non-pipelined and one pipelined client, each with a write-first BRAM model.
module tb_bram_port_client;

`ifdef BRAM_PORT_CLIENT_WRITE_ACK_EN
   localparam bit WACK = 1'b1;
`else
   localparam bit WACK = 1'b0;
`endif

   logic        clk, rst;
   logic        req_valid0, req_rdy0, resp_valid0, resp_rdy0, bram_en0;
   logic [3:0]  req_we0, bram_we0;
   logic [15:0] req_addr0, bram_addr0;
   logic [31:0] req_data0, resp_data0, bram_di0, bram_do0;
   logic        req_valid1, req_rdy1, resp_valid1, resp_rdy1, bram_en1;
   logic [3:0]  req_we1, bram_we1;
   logic [15:0] req_addr1, bram_addr1;
   logic [31:0] req_data1, resp_data1, bram_di1, bram_do1;

   bram_port_client #(.PIPELINED(0), .RESP_DEPTH(4)) dut0 (
      .CLK(clk), .RST(rst), .REQ_VALID(req_valid0), .REQ_RDY(req_rdy0), .REQ_WE(req_we0),
      .REQ_ADDR(req_addr0), .REQ_DATA(req_data0), .RESP_VALID(resp_valid0), .RESP_RDY(resp_rdy0),
      .RESP_DATA(resp_data0), .BRAM_EN(bram_en0), .BRAM_WE(bram_we0), .BRAM_ADDR(bram_addr0),
      .BRAM_DI(bram_di0), .BRAM_DO(bram_do0));

   bram_port_client #(.PIPELINED(1), .RESP_DEPTH(4)) dut1 (
      .CLK(clk), .RST(rst), .REQ_VALID(req_valid1), .REQ_RDY(req_rdy1), .REQ_WE(req_we1),
      .REQ_ADDR(req_addr1), .REQ_DATA(req_data1), .RESP_VALID(resp_valid1), .RESP_RDY(resp_rdy1),
      .RESP_DATA(resp_data1), .BRAM_EN(bram_en1), .BRAM_WE(bram_we1), .BRAM_ADDR(bram_addr1),
      .BRAM_DI(bram_di1), .BRAM_DO(bram_do1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write-first byte-enable BRAM models
   logic [31:0] mem0 [65536];
   logic [31:0] mem1 [65536];
   logic [31:0] wf0, wf1, do1_s;

   always_comb begin
      wf0 = mem0[bram_addr0];
      for (int l = 0; l < 4; l++) if (bram_we0[l]) wf0[l*8 +: 8] = bram_di0[l*8 +: 8];
   end
   always_comb begin
      wf1 = mem1[bram_addr1];
      for (int l = 0; l < 4; l++) if (bram_we1[l]) wf1[l*8 +: 8] = bram_di1[l*8 +: 8];
   end
   always_ff @(posedge clk) begin
      if (bram_en0) begin
         mem0[bram_addr0] <= wf0;
         bram_do0         <= wf0;
      end
   end
   always_ff @(posedge clk) begin
      if (bram_en1) begin
         mem1[bram_addr1] <= wf1;
         do1_s            <= wf1;
      end
      bram_do1 <= do1_s;
   end

   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
      bit          chk_lat;
   } exp_t;

   typedef struct {
      logic [3:0]  we;
      logic [15:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   exp_t        q0[$];
   exp_t        q1[$];
   vec_t        tbl[11];
   int          n_tests, n_fail, pops0, vcyc1;
   int unsigned cyc;
   bit          fired0, fired1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: compare responses and record fires mid-cycle, then step to #1 after the edge
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (resp_valid0 && resp_rdy0) begin
         pops0++;
         if (q0.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexp_resp0: got %h required none", resp_data0);
         end else begin
            e = q0.pop_front();
            chk("resp0_data", resp_data0, e.data);
            if (e.chk_lat) chk("resp0_lat", 32'(cyc - e.cyc), 32'd2);
         end
      end
      if (resp_valid1) vcyc1++;
      if (resp_valid1 && resp_rdy1) begin
         if (q1.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexp_resp1: got %h required none", resp_data1);
         end else begin
            e = q1.pop_front();
            chk("resp1_data", resp_data1, e.data);
            if (e.chk_lat) chk("resp1_lat", 32'(cyc - e.cyc), 32'd3);
         end
      end
      fired0 = req_valid0 && req_rdy0;
      fired1 = req_valid1 && req_rdy1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Present a request and wait for it to fire; REQ_VALID is left high for back-to-back use
   task automatic issue(input int sel, input logic [3:0] we, input logic [15:0] addr,
                        input logic [31:0] data, input logic [31:0] exp, input bit resp, input bit lat);
      exp_t e;
      if (sel == 0) begin
         req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_data0 = data;
      end else begin
         req_valid1 = 1'b1; req_we1 = we; req_addr1 = addr; req_data1 = data;
      end
      for (int i = 0; i < 100; i++) begin
         tick();
         if ((sel == 0) ? fired0 : fired1) begin
            if (resp) begin
               e.data = exp; e.cyc = cyc - 1; e.chk_lat = lat;
               if (sel == 0) q0.push_back(e); else q1.push_back(e);
            end
            return;
         end
      end
      n_tests++; n_fail++;
      $display("FAIL issue_timeout: dut%0d addr %h never accepted", sel, addr);
   endtask

   task automatic drain();
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) tick();
      for (int i = 0; i < 4; i++) tick();
      chk("drain_left", 32'(q0.size() + q1.size()), 32'd0);
   endtask

   int unsigned c0;
   int          nf, p_before;

   initial begin
      n_tests = 0; n_fail = 0; pops0 = 0; vcyc1 = 0; cyc = 0;
      rst = 1'b1;
      req_valid0 = 1'b0; req_we0 = '0; req_addr0 = '0; req_data0 = '0; resp_rdy0 = 1'b1;
      req_valid1 = 1'b0; req_we1 = '0; req_addr1 = '0; req_data1 = '0; resp_rdy1 = 1'b1;

      tbl[0]  = '{4'hF, 16'd5,  32'hDEADBEEF, 32'hDEADBEEF};
      tbl[1]  = '{4'h0, 16'd5,  32'h0,        32'hDEADBEEF};
      tbl[2]  = '{4'hF, 16'd3,  32'h11223344, 32'h11223344};
      tbl[3]  = '{4'h5, 16'd3,  32'hAABBCCDD, 32'h11BB33DD};
      tbl[4]  = '{4'h0, 16'd3,  32'h0,        32'h11BB33DD};
      tbl[5]  = '{4'hF, 16'd7,  32'h00000000, 32'h00000000};
      tbl[6]  = '{4'h2, 16'd7,  32'h12345678, 32'h00005600};
      tbl[7]  = '{4'h0, 16'd7,  32'h0,        32'h00005600};
      tbl[8]  = '{4'h0, 16'd5,  32'h0,        32'hDEADBEEF};
      tbl[9]  = '{4'hF, 16'd10, 32'hCAFEF00D, 32'hCAFEF00D};
      tbl[10] = '{4'h0, 16'd10, 32'h0,        32'hCAFEF00D};

      // Reset state
      for (int i = 0; i < 3; i++) tick();
      chk("rst_req_rdy0",  {31'd0, req_rdy0},    32'd0);
      chk("rst_resp_vld0", {31'd0, resp_valid0}, 32'd0);
      chk("rst_bram_en0",  {31'd0, bram_en0},    32'd0);
      chk("rst_bram_we0",  {28'd0, bram_we0},    32'd0);
      chk("rst_resp_vld1", {31'd0, resp_valid1}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_rdy0", {31'd0, req_rdy0}, 32'd1);

      // Table: back-to-back writes/reads on the non-pipelined port
      for (int i = 0; i < 11; i++)
         issue(0, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].exp,
               (tbl[i].we == '0) || WACK, tbl[i].we == '0);
      drain();

      // Write acknowledge option: lane-3 write onto 11223344
      p_before = pops0;
      issue(0, 4'hF, 16'd3, 32'h11223344, 32'h11223344, WACK, 1'b0);
      issue(0, 4'h8, 16'd3, 32'h99000000, 32'h99223344, WACK, 1'b0);
      drain();
      chk("write_ack_count", 32'(pops0 - p_before), WACK ? 32'd2 : 32'd0);
      issue(0, 4'h0, 16'd3, 32'h0, 32'h99223344, 1'b1, 1'b1);
      drain();

      // Backpressure: credits stop acceptance at RESP_DEPTH
      for (int a = 16; a < 22; a++)
         issue(0, 4'hF, 16'(a), 32'h30000000 | 32'(a), 32'h30000000 | 32'(a), WACK, 1'b0);
      drain();
      resp_rdy0 = 1'b0;
      c0 = cyc;
      for (int a = 16; a < 20; a++) issue(0, 4'h0, 16'(a), 32'h0, 32'h30000000 | 32'(a), 1'b1, 1'b0);
      chk("bp_4_b2b", 32'(cyc - c0), 32'd4);
      req_valid0 = 1'b1; req_we0 = 4'h0; req_addr0 = 16'd20; req_data0 = 32'h0;
      nf = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (fired0) nf++;
      end
      chk("bp_no_accept", 32'(nf), 32'd0);
      chk("bp_rdy_low", {31'd0, req_rdy0}, 32'd0);
      chk("bp_hold_vld", {31'd0, resp_valid0}, 32'd1);
      chk("bp_hold_data", resp_data0, 32'h30000010);
      resp_rdy0 = 1'b1;
      issue(0, 4'h0, 16'd20, 32'h0, 32'h30000014, 1'b1, 1'b0);
      issue(0, 4'h0, 16'd21, 32'h0, 32'h30000015, 1'b1, 1'b0);
      drain();

      // Streaming on the pipelined port: 16 reads, one per cycle
      for (int a = 0; a < 16; a++)
         issue(1, 4'hF, 16'(a), 32'h5A000000 + 32'(a), 32'h5A000000 + 32'(a), WACK, 1'b0);
      drain();
      c0 = cyc;
      for (int a = 0; a < 16; a++) issue(1, 4'h0, 16'(a), 32'h0, 32'h5A000000 + 32'(a), 1'b1, 1'b1);
      chk("stream_16_cycles", 32'(cyc - c0), 32'd16);
      drain();

      // Reset while two pipelined reads are in flight
      issue(1, 4'hF, 16'd20, 32'h12345678, 32'h12345678, WACK, 1'b0);
      issue(1, 4'hF, 16'd21, 32'h0BADF00D, 32'h0BADF00D, WACK, 1'b0);
      drain();
      issue(1, 4'h0, 16'd20, 32'h0, 32'h0, 1'b0, 1'b0);
      issue(1, 4'h0, 16'd21, 32'h0, 32'h0, 1'b0, 1'b0);
      req_valid1 = 1'b0;
      rst = 1'b1;
      vcyc1 = 0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("rst_flight_novld", 32'(vcyc1), 32'd0);
      chk("rst_flight_cnt", 32'(dut1.cnt_q), 32'd0);
      chk("rst_flight_rdy", {31'd0, req_rdy1}, 32'd1);
      issue(1, 4'h0, 16'd20, 32'h0, 32'h12345678, 1'b1, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
